// File: rtl/fifo_stream_packer.sv
// Packs PACK registered FIFO read words into one wide valid/ready beat, lane 0 first; flush closes a partial beat.
// Output is registered, and a full beat appears one cycle after its last lane lands; reads stall while m_valid is held without m_ready.
module fifo_stream_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_dout,
    output logic                       fifo_rd_en,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       m_last,
    output logic                       flush_done
);

    localparam int              CW       = $clog2(PACK + 1);
    localparam int              W        = DATA_WIDTH * PACK;
    localparam logic [CW-1:0]   CNT_FULL = CW'(PACK);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH_EMIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pending_q, pending_d;
    logic [W-1:0]    pack_q, pack_d;
    logic            m_valid_q, m_valid_d;
    logic [W-1:0]    m_data_q, m_data_d;
    logic [PACK-1:0] m_keep_q, m_keep_d;
    logic            m_last_q, m_last_d;
    logic            flush_done_q, flush_done_d;

    logic            xfer_ok;
    logic            cnt_full;
    logic [CW:0]     cnt_sum;
    logic            room;
    logic            load_full;
    logic            load_flush;
    logic [PACK-1:0] part_keep;

    // A read is only issued when its word is sure to have a lane to land in.
    always_comb begin
        xfer_ok    = !m_valid_q || m_ready;
        cnt_full   = (cnt_q == CNT_FULL);
        cnt_sum    = {1'b0, cnt_q} + {{CW{1'b0}}, pending_q};
        room       = (cnt_sum < {1'b0, CNT_FULL}) || (cnt_full && xfer_ok);
        fifo_rd_en = (state_q == RUN) && !fifo_empty && room;
        load_full  = (state_q == RUN) && cnt_full && xfer_ok;
        load_flush = (state_q == FLUSH_EMIT) && xfer_ok;
        for (int i = 0; i < PACK; i++) begin
            part_keep[i] = (CW'(i) < cnt_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pack_d       = pack_q;
        pending_d    = fifo_rd_en && !fifo_empty;
        m_valid_d    = m_valid_q && !m_ready;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;
        flush_done_d = 1'b0;

        if (pending_q) begin
            for (int i = 0; i < PACK; i++) begin
                if (cnt_q == CW'(i)) begin
                    pack_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
                end
            end
            cnt_d = cnt_q + CW'(1);
        end

        // Clearing the pack register on every load keeps unwritten lanes at zero.
        if (load_full || load_flush) begin
            m_valid_d = 1'b1;
            m_data_d  = pack_q;
            m_keep_d  = load_flush ? part_keep : {PACK{1'b1}};
            m_last_d  = load_flush;
            pack_d    = '0;
            cnt_d     = '0;
        end

        case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (!pending_q) begin
                    if (cnt_q == '0) begin
                        flush_done_d = 1'b1;
                        state_d      = RUN;
                    end else begin
                        state_d = FLUSH_EMIT;
                    end
                end
            end
            FLUSH_EMIT: begin
                if (xfer_ok) begin
                    flush_done_d = 1'b1;
                    state_d      = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            pack_q       <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            pack_q       <= pack_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_keep     = m_keep_q;
    assign m_last     = m_last_q;
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_fifo_stream_packer.sv
// Directed bench for fifo_stream_packer (DATA_WIDTH=8, PACK=4) with a registered-read FIFO model.
module tb_fifo_stream_packer;

    typedef struct packed {
        logic        done;
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_en;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        flush_done;

    logic [7:0]  mem [0:63];
    logic [5:0]  wr_ptr = 6'd0;
    logic [5:0]  rd_ptr = 6'd0;

    word_t obs[$];
    int    rd_cnt = 0;
    int    fd_cnt = 0;
    int    nvec = 0;
    int    nerr = 0;

    fifo_stream_packer #(.DATA_WIDTH(8), .PACK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= wr_ptr;
            fifo_dout <= 8'h00;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 6'd1;
        end
    end

    always @(negedge clk) begin
        word_t w;
        if (rst_n) begin
            if (fifo_rd_en) rd_cnt = rd_cnt + 1;
            if (flush_done) fd_cnt = fd_cnt + 1;
            if (m_valid && m_ready) begin
                w.done = flush_done;
                w.last = m_last;
                w.keep = m_keep;
                w.data = m_data;
                obs.push_back(w);
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int k = 0; k < budget && obs.size() < n; k++) step(1);
    endtask

    function automatic word_t get_obs(input int i);
        word_t w;
        w = '0;
        if (i < obs.size()) w = obs[i];
        return w;
    endfunction

    initial begin
        int    base;
        int    rd0;
        int    fd0;
        word_t w;

        #1 rst_n = 1'b0;
        #2;
        chk_eq("rst_m_valid", 64'(m_valid), 64'd0);
        chk_eq("rst_m_data", 64'(m_data), 64'd0);
        chk_eq("rst_m_keep", 64'(m_keep), 64'd0);
        chk_eq("rst_m_last", 64'(m_last), 64'd0);
        chk_eq("rst_flush_done", 64'(flush_done), 64'd0);
        chk_eq("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Full word, downstream always ready.
        base = obs.size();
        rd0  = rd_cnt;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_obs(base + 1, 20);
        step(2);
        w = get_obs(base);
        chk_eq("t1_nwords", 64'(obs.size() - base), 64'd1);
        chk_eq("t1_data", 64'(w.data), 64'h44332211);
        chk_eq("t1_keep", 64'(w.keep), 64'hF);
        chk_eq("t1_last", 64'(w.last), 64'd0);
        chk_eq("t1_rd_pulses", 64'(rd_cnt - rd0), 64'd4);
        chk_eq("t1_valid_drop", 64'(m_valid), 64'd0);

        // Flush after two lanes landed.
        do_reset();
        base = obs.size();
        fd0  = fd_cnt;
        push(8'hA1); push(8'hA2);
        step(6);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        wait_obs(base + 1, 20);
        step(2);
        w = get_obs(base);
        chk_eq("t2_nwords", 64'(obs.size() - base), 64'd1);
        chk_eq("t2_data", 64'(w.data), 64'h0000A2A1);
        chk_eq("t2_keep", 64'(w.keep), 64'h3);
        chk_eq("t2_last", 64'(w.last), 64'd1);
        chk_eq("t2_done_with_load", 64'(w.done), 64'd1);
        chk_eq("t2_done_pulses", 64'(fd_cnt - fd0), 64'd1);

        // Flush while the third word is still in flight.
        do_reset();
        base = obs.size();
        rd0  = rd_cnt;
        push(8'h31); push(8'h32); push(8'h33);
        step(3);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        push(8'h34);
        for (int k = 0; k < 10 && !flush_done; k++) step(1);
        chk_eq("t3_flush_done", 64'(flush_done), 64'd1);
        chk_eq("t3_rd_pulses", 64'(rd_cnt - rd0), 64'd3);
        wait_obs(base + 1, 10);
        w = get_obs(base);
        chk_eq("t3_data", 64'(w.data), 64'h00333231);
        chk_eq("t3_keep", 64'(w.keep), 64'h7);
        chk_eq("t3_last", 64'(w.last), 64'd1);

        // Backpressure: first word held, no read beyond landing space.
        do_reset();
        m_ready = 1'b0;
        base = obs.size();
        rd0  = rd_cnt;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        push(8'h99);
        step(6);
        chk_eq("t4_valid_up", 64'(m_valid), 64'd1);
        for (int k = 0; k < 6; k++) begin
            chk_eq("t4_hold_data", 64'(m_data), 64'h44332211);
            step(1);
        end
        chk_eq("t4_hold_valid", 64'(m_valid), 64'd1);
        chk_eq("t4_rd_stalled", 64'(rd_cnt - rd0), 64'd8);
        m_ready = 1'b1;
        wait_obs(base + 2, 20);
        step(3);
        chk_eq("t4_nwords", 64'(obs.size() - base), 64'd2);
        w = get_obs(base);
        chk_eq("t4_word0", 64'(w.data), 64'h44332211);
        w = get_obs(base + 1);
        chk_eq("t4_word1", 64'(w.data), 64'h88776655);
        chk_eq("t4_keep1", 64'(w.keep), 64'hF);
        chk_eq("t4_last1", 64'(w.last), 64'd0);
        chk_eq("t4_rd_total", 64'(rd_cnt - rd0), 64'd9);

        // Flush with nothing collected.
        do_reset();
        base = obs.size();
        fd0  = fd_cnt;
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        for (int k = 0; k < 1 && !flush_done; k++) step(1);
        chk_eq("t5_flush_done", 64'(flush_done), 64'd1);
        step(3);
        chk_eq("t5_done_pulses", 64'(fd_cnt - fd0), 64'd1);
        chk_eq("t5_no_word", 64'(obs.size() - base), 64'd0);
        chk_eq("t5_valid_low", 64'(m_valid), 64'd0);

        // Reset mid-word, then fresh packing from lane 0.
        do_reset();
        push(8'h41); push(8'h42); push(8'h43);
        step(3);
        rst_n = 1'b0;
        #1;
        chk_eq("t6_rst_valid", 64'(m_valid), 64'd0);
        chk_eq("t6_rst_data", 64'(m_data), 64'd0);
        chk_eq("t6_rst_keep", 64'(m_keep), 64'd0);
        chk_eq("t6_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk_eq("t6_rst_done", 64'(flush_done), 64'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        base = obs.size();
        push(8'h51); push(8'h52); push(8'h53); push(8'h54);
        wait_obs(base + 1, 20);
        w = get_obs(base);
        chk_eq("t6_data", 64'(w.data), 64'h54535251);
        chk_eq("t6_keep", 64'(w.keep), 64'hF);
        chk_eq("t6_last", 64'(w.last), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fifo_stream_packer.md
Name: fifo_stream_packer

Overview:
- Read-side adapter that sits directly downstream of the team's synchronous FIFO.
- Drives the FIFO's rd_en from its empty flag and captures the registered dout one cycle after each accepted read.
- Packs PACK consecutive FIFO words into one wide word, LSB lane first.
- Presents packed words on a valid/ready stream, with a flush command that emits a partial final word.

Parameters:
- DATA_WIDTH, 8: width of one FIFO word / one lane.
- PACK, 4: lanes per output word; legal range 1..16.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  empty flag from the upstream FIFO.
- fifo_dout  in  DATA_WIDTH  registered FIFO read data, valid the cycle after an accepted rd_en.
- fifo_rd_en  out  1  read request to the FIFO.
- flush  in  1  single-cycle pulse: close the current word early.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH*PACK  packed word; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_keep  out  PACK  lane-valid mask, lane 0 first.
- m_last  out  1  word was closed by flush.
- flush_done  out  1  one-cycle pulse when a flush completes.

Behaviour:
- Reset: fifo_rd_en=0, m_valid=0, m_data=0, m_keep=0, m_last=0, flush_done=0, cnt=0, pending=0, state=RUN.
- Reset mid-operation discards any in-flight read and the partial word. The FIFO is reset from the same rst_n.
- pending: registered (fifo_rd_en && !fifo_empty). It marks that fifo_dout carries new data this cycle.
- Capture: when pending=1, fifo_dout is written into lane cnt of the pack register and cnt increments.
  - Written lanes hold their value until transferred.
  - Unwritten lanes read as 0.
- xfer_ok = !m_valid || m_ready.
- fifo_rd_en (combinational) = state==RUN && !fifo_empty && (cnt+pending < PACK || (cnt==PACK && xfer_ok)).
  - Never issue a read without guaranteed landing space.
  - FIFO overread protection is the FIFO's own job; rd_en is still qualified with !fifo_empty.
- Transfer pack -> output register when cnt==PACK && xfer_ok:
  - m_data gets the pack register.
  - m_keep = all ones.
  - m_last = 0, except during FLUSH_EMIT, where it is 1.
  - cnt is cleared.
- Throughput: at most PACK FIFO words per PACK+1 cycles. The one-cycle bubble at cnt=PACK-1 with pending=1 is accepted behaviour.
- Output handshake:
  - m_valid stays high, and m_data/m_keep/m_last stay stable, until m_valid && m_ready.
  - When m_ready=1 with a new transfer in the same cycle, the new word replaces the old one with no bubble.
  - When m_ready=1 and there is no transfer, m_valid drops next cycle.
- State machine: RUN, FLUSH_WAIT, FLUSH_EMIT.
  - RUN --flush--> FLUSH_WAIT. From here on fifo_rd_en=0.
  - FLUSH_WAIT: wait until pending=0 (the in-flight word has landed). Then:
    - cnt==0 -> pulse flush_done, go to RUN; no word emitted.
    - otherwise -> FLUSH_EMIT.
  - FLUSH_EMIT: when xfer_ok, load the output with:
    - m_data = pack register, unused lanes 0;
    - m_keep = (1<<cnt)-1;
    - m_last = 1;
    - then cnt=0, pulse flush_done in the same cycle, go to RUN.
  - A flush arriving in the same cycle as a full-word transfer applies to the next word. If that word is empty, there is no output, only flush_done.
  - flush while not in RUN is ignored.
- Arithmetic: cnt is $clog2(PACK+1) bits and never exceeds PACK.

Test Plan:
- DATA_WIDTH=8, PACK=4, m_ready=1, FIFO preloaded 0x11,0x22,0x33,0x44 -> one word m_data=0x44332211, m_keep=4'hF, m_last=0; exactly 4 fifo_rd_en pulses.
- Preload 0xA1,0xA2 then flush once both have landed -> m_data=0x0000A2A1, m_keep=4'h3, m_last=1; flush_done coincident with the load.
- flush pulsed the cycle after the 3rd rd_en (pending=1) -> no further rd_en; the 3rd word is included; m_keep=4'h7, m_last=1.
- 8 words streamed with m_ready held 0 for 6 cycles -> the first packed word is held stable and no rd_en is issued past 4 lanes. After release: 0x44332211 then 0x88776655, no loss, no duplication.
- flush with cnt=0 and pending=0 -> flush_done pulses within 2 cycles; m_valid stays 0.
- rst_n asserted mid-word (cnt=2, pending=1) -> all outputs 0 immediately. After release, fresh data packs from lane 0.
